// File: rtl/edge_pkg.sv
// Shared types and helpers for the edge-detector SRAM datapath.
//   NUM_PIX    : default pixel buffer depth
//   PIX_BITS   : processed pixel width
//   WORD_BITS  : SRAM word width
//   CntBits    : width of pixel count / index fields
//   wb_state_e : write-back sequencer states
//   expand_pix : pixel -> 24-bit SRAM word (grayscale replicate or binary)
package edge_pkg;

  localparam int unsigned NUM_PIX   = 20;
  localparam int unsigned PIX_BITS  = 8;
  localparam int unsigned WORD_BITS = 24;
  localparam int unsigned CntBits   = 5;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StWrite,
    StRecover,
    StDone
  } wb_state_e;

  // mode 0: {p,p,p}; mode 1: any non-zero pixel saturates to white.
  function automatic logic [WORD_BITS-1:0] expand_pix(input logic [PIX_BITS-1:0] p,
                                                      input logic                mode);
    if (mode) begin
      return (p != '0) ? {WORD_BITS{1'b1}} : '0;
    end
    return {p, p, p};
  endfunction

endpackage

// File: rtl/wr_timer.sv
// Loadable down-counter timing the WRITE and RECOVER dwell of the write-back
// sequencer. Loading value V makes zero rise V cycles later; the counter
// parks at zero until loaded again.
//   clk, n_rst : clock, asynchronous active-low reset
//   load       : load load_val this cycle (takes priority over counting)
//   load_val   : value to load
//   zero       : counter is at zero
module wr_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             zero
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - Width'(1);
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/pixel_writeback.sv
// Write-side SRAM master: writes a latched buffer of processed pixels to the
// off-chip SRAM, one 24-bit word per bus transaction, starting at a word
// offset. Each pixel takes SETUP (1) + WRITE (WR_HOLD) + RECOVER (GAP) cycles.
//   clk, n_rst           : clock, asynchronous active-low reset
//   start                : job request, sampled only in IDLE
//   data_in              : packed pixel buffer, element i -> offset + i
//   num_pix_write        : pixels to write, clamped to NUM_PIX
//   address_write_offset : first word address
//   mode                 : 0 grayscale replicate, 1 binary
//   busy                 : job in progress (cycle after accept through DONE)
//   done                 : one-cycle pulse at job end
//   address, w_data      : SRAM word address and write data
//   write_enable         : SRAM write strobe
//   read_enable          : always low, this block never reads
module pixel_writeback #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned NUM_PIX   = edge_pkg::NUM_PIX,
  parameter int unsigned WR_HOLD   = 2,
  parameter int unsigned GAP       = 1
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic                                  start,
  input  logic [NUM_PIX*edge_pkg::PIX_BITS-1:0] data_in,
  input  logic [edge_pkg::CntBits-1:0]          num_pix_write,
  input  logic [ADDR_BITS-1:0]                  address_write_offset,
  input  logic                                  mode,
  output logic                                  busy,
  output logic                                  done,
  output logic [ADDR_BITS-1:0]                  address,
  output logic [edge_pkg::WORD_BITS-1:0]        w_data,
  output logic                                  write_enable,
  output logic                                  read_enable
);

  import edge_pkg::*;

  localparam int unsigned DwellMax = (WR_HOLD > GAP) ? WR_HOLD : GAP;
  localparam int unsigned TimerW   = (DwellMax > 1) ? $clog2(DwellMax) : 1;
  localparam logic [CntBits-1:0] NumPixCnt = CntBits'(NUM_PIX);

  wb_state_e              state_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   we_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [WORD_BITS-1:0]   wdata_q;
  logic [CntBits-1:0]     idx_q;
  logic [CntBits-1:0]     count_q;
  logic [ADDR_BITS-1:0]   offset_q;
  logic                   mode_q;
  logic [PIX_BITS-1:0]    pix_q [NUM_PIX];

  logic [CntBits-1:0]     count_clamped;
  logic [CntBits-1:0]     idx_inc;
  logic                   accept;

  logic                   tmr_load;
  logic [TimerW-1:0]      tmr_val;
  logic                   tmr_zero;

  assign accept        = (state_q == StIdle) && start;
  assign count_clamped = (num_pix_write > NumPixCnt) ? NumPixCnt : num_pix_write;
  assign idx_inc       = idx_q + CntBits'(1);

  // The dwell timer is armed one cycle ahead: loaded in SETUP for the WRITE
  // window and on the last WRITE cycle for the RECOVER window, so a loaded
  // value of N-1 yields exactly N cycles in the following state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (state_q == StSetup) begin
      tmr_load = 1'b1;
      tmr_val  = TimerW'(WR_HOLD - 1);
    end else if ((state_q == StWrite) && tmr_zero) begin
      tmr_load = 1'b1;
      tmr_val  = TimerW'(GAP - 1);
    end
  end

  wr_timer #(
    .Width (TimerW)
  ) u_wr_timer (
    .clk      (clk),
    .n_rst    (n_rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Pixel buffer snapshot taken at accept; the job never looks at data_in again.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_PIX; i++) begin
        pix_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NUM_PIX; i++) begin
        pix_q[i] <= data_in[i*PIX_BITS +: PIX_BITS];
      end
    end
  end

  // Sequencer with registered bus outputs. address/w_data only change on entry
  // to SETUP, so they are stable across SETUP, WRITE and RECOVER.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      idx_q    <= '0;
      count_q  <= '0;
      offset_q <= '0;
      mode_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            offset_q <= address_write_offset;
            mode_q   <= mode;
            count_q  <= count_clamped;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            if (count_clamped == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StSetup;
              addr_q  <= address_write_offset;
              wdata_q <= expand_pix(data_in[PIX_BITS-1:0], mode);
            end
          end
        end
        StSetup: begin
          state_q <= StWrite;
          we_q    <= 1'b1;
        end
        StWrite: begin
          if (tmr_zero) begin
            state_q <= StRecover;
            we_q    <= 1'b0;
          end
        end
        StRecover: begin
          if (tmr_zero) begin
            if (idx_inc < count_q) begin
              idx_q   <= idx_inc;
              // Address wraps modulo 2^ADDR_BITS by construction.
              addr_q  <= offset_q + ADDR_BITS'(idx_inc);
              wdata_q <= expand_pix(pix_q[idx_inc], mode_q);
              state_q <= StSetup;
            end else begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign address      = addr_q;
  assign w_data       = wdata_q;
  assign write_enable = we_q;
  assign read_enable  = 1'b0;

endmodule

// File: tb/tb_pixel_writeback.sv
// Randomized self-checking bench for pixel_writeback. A bus monitor turns
// write_enable pulses into (address, data, length, start cycle) records; a
// behavioural model produces the expected list of SRAM writes per job.
module tb_pixel_writeback;

  localparam int NP = 20;

  typedef struct {
    logic [15:0] addr;
    logic [23:0] data;
    int          len;
    int          rise;
  } wr_t;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [159:0]  data_in;
  logic [4:0]    num_pix_write;
  logic [15:0]   address_write_offset;
  logic          mode;
  logic          busy, done;
  logic [15:0]   address;
  logic [23:0]   w_data;
  logic          write_enable, read_enable;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int e0       = 0;

  wr_t         wr_q[$];
  wr_t         exp_q[$];
  logic [23:0] dut_mem   [logic [15:0]];
  logic [23:0] model_mem [logic [15:0]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_writeback #(
    .ADDR_BITS (16),
    .NUM_PIX   (NP),
    .WR_HOLD   (2),
    .GAP       (1)
  ) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .start                (start),
    .data_in              (data_in),
    .num_pix_write        (num_pix_write),
    .address_write_offset (address_write_offset),
    .mode                 (mode),
    .busy                 (busy),
    .done                 (done),
    .address              (address),
    .w_data               (w_data),
    .write_enable         (write_enable),
    .read_enable          (read_enable)
  );

  // ---------------- bus monitor ----------------
  logic        we_prev = 1'b0;
  logic [15:0] cur_addr, prev_addr;
  logic [23:0] cur_data, prev_data;
  int          cur_len = 0, cur_rise = 0;
  int          unstable = 0, re_seen = 0, xz_seen = 0;

  always @(negedge clk) begin
    if (!n_rst) begin
      we_prev = 1'b0;
      cur_len = 0;
    end else begin
      if ($isunknown({busy, done, address, w_data, write_enable, read_enable})) xz_seen++;
      if (read_enable) re_seen++;
      if (write_enable && !we_prev) begin
        // rising strobe: bus must already match what SETUP presented
        if (address !== prev_addr || w_data !== prev_data) unstable++;
        cur_addr = address;
        cur_data = w_data;
        cur_len  = 0;
        cur_rise = cyc;
      end
      if (write_enable) cur_len++;
      if ((write_enable || we_prev) && (address !== cur_addr || w_data !== cur_data)) unstable++;
      if (we_prev && !write_enable) begin
        wr_q.push_back('{cur_addr, cur_data, cur_len, cur_rise});
        dut_mem[cur_addr] = cur_data;
      end
      we_prev   = write_enable;
      prev_addr = address;
      prev_data = w_data;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [159:0] rand_buf();
    logic [159:0] b;
    for (int i = 0; i < 5; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic int exp_count(input int n);
    return (n > NP) ? NP : n;
  endfunction

  task automatic model_job(input logic [159:0] d, input int n, input logic [15:0] off,
                           input logic m);
    exp_q.delete();
    for (int i = 0; i < exp_count(n); i++) begin
      logic [7:0] p;
      wr_t        w;
      p      = d[i*8 +: 8];
      w.addr = off + 16'(i);
      w.data = m ? ((p != 8'h00) ? 24'hFFFFFF : 24'h000000) : {3{p}};
      w.len  = 2;
      w.rise = 0;
      exp_q.push_back(w);
      model_mem[w.addr] = w.data;
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic start_job(input logic [159:0] d, input int n, input logic [15:0] off,
                           input logic m);
    @(negedge clk);
    wr_q.delete();
    data_in              = d;
    num_pix_write        = 5'(n);
    address_write_offset = off;
    mode                 = m;
    start                = 1'b1;
    @(posedge clk);
    #1;
    e0    = cyc;
    start = 1'b0;
    // scramble inputs: the job must run from its latched copy
    data_in              = rand_buf();
    num_pix_write        = 5'($urandom_range(0, 31));
    address_write_offset = 16'($urandom);
    mode                 = 1'($urandom);
  endtask

  // done sampled at the first negedge after edge e0 + 4N
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = cyc - e0;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; data_in = '0; num_pix_write = '0;
    address_write_offset = '0; mode = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, write_enable, read_enable, address, w_data} !== '0)
      $display("FAIL reset_outputs: got busy=%b done=%b we=%b re=%b addr=%h data=%h, want all 0",
               busy, done, write_enable, read_enable, address, w_data);
    else n_pass++;
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({busy, done, write_enable} !== 3'b000)
      $display("FAIL reset_idle: got busy=%b done=%b we=%b, want 0 0 0", busy, done, write_enable);
    else n_pass++;
  endtask

  task automatic test_gray_full();
    logic [159:0] d;
    int lat, bad;
    for (int i = 0; i < NP; i++) d[i*8 +: 8] = 8'(i * 8);
    model_job(d, 20, 16'h0100, 1'b0);
    start_job(d, 20, 16'h0100, 1'b0);
    wait_done(lat);
    n_checks++;
    if (lat != 80) $display("FAIL gray_latency: got %0d, want 80", lat); else n_pass++;
    n_checks++;
    if (wr_q.size() != exp_q.size())
      $display("FAIL gray_count: got %0d writes, want %0d", wr_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data || wr_q[i].len != 2 ||
          (i > 0 && wr_q[i].rise - wr_q[i-1].rise != 4))
        $display("FAIL gray_write[%0d]: got %h<=%h len %0d, want %h<=%h len 2 period 4",
                 i, wr_q[i].addr, wr_q[i].data, wr_q[i].len, exp_q[i].addr, exp_q[i].data);
      else n_pass++;
    end
    n_checks++;
    if (wr_q.size() < 8 || wr_q[7].addr !== 16'h0107 || wr_q[7].data !== 24'h383838)
      $display("FAIL gray_0107: got %h<=%h, want 0107<=383838",
               (wr_q.size() > 7) ? wr_q[7].addr : 16'hxxxx,
               (wr_q.size() > 7) ? wr_q[7].data : 24'hxxxxxx);
    else n_pass++;
    bad = 0;
    for (int a = 16'h0100; a <= 16'h0113; a++)
      if (!dut_mem.exists(16'(a)) || dut_mem[16'(a)] !== model_mem[16'(a)]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL gray_dump: got %0d bad words, want 0", bad); else n_pass++;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL gray_busy_end: got %b, want 0", busy); else n_pass++;
  endtask

  task automatic test_binary();
    logic [159:0] d;
    logic [23:0]  want [4];
    int lat;
    want = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
    d = rand_buf();
    d[31:0] = 32'h00FF0100;
    start_job(d, 4, 16'h0200, 1'b1);
    wait_done(lat);
    n_checks++;
    if (lat != 16) $display("FAIL bin_latency: got %0d, want 16", lat); else n_pass++;
    n_checks++;
    if (wr_q.size() != 4) $display("FAIL bin_count: got %0d, want 4", wr_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i].data !== want[i] || wr_q[i].addr !== 16'h0200 + 16'(i))
        $display("FAIL bin_write[%0d]: got %h<=%h, want %h<=%h",
                 i, wr_q[i].addr, wr_q[i].data, 16'h0200 + 16'(i), want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_count_limits();
    logic [159:0] d;
    int lat;
    d = rand_buf();
    start_job(d, 0, 16'h0300, 1'b0);
    wait_done(lat);
    repeat (3) @(negedge clk);
    n_checks++;
    if (lat != 0) $display("FAIL zero_latency: got %0d, want 0", lat); else n_pass++;
    n_checks++;
    if (wr_q.size() != 0) $display("FAIL zero_writes: got %0d, want 0", wr_q.size()); else n_pass++;
    d = rand_buf();
    model_job(d, 25, 16'h0400, 1'b0);
    start_job(d, 25, 16'h0400, 1'b0);
    wait_done(lat);
    n_checks++;
    if (lat != 80) $display("FAIL clamp_latency: got %0d, want 80", lat); else n_pass++;
    n_checks++;
    if (wr_q.size() != 20) $display("FAIL clamp_count: got %0d, want 20", wr_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data)
        $display("FAIL clamp_write[%0d]: got %h<=%h, want %h<=%h",
                 i, wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic [159:0] d;
    logic [15:0]  want [4];
    int lat;
    want = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    d = rand_buf();
    model_job(d, 4, 16'hFFFE, 1'b0);
    start_job(d, 4, 16'hFFFE, 1'b0);
    wait_done(lat);
    n_checks++;
    if (wr_q.size() != 4) $display("FAIL wrap_count: got %0d, want 4", wr_q.size()); else n_pass++;
    for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i].addr !== want[i] || wr_q[i].data !== exp_q[i].data)
        $display("FAIL wrap_write[%0d]: got %h<=%h, want %h<=%h",
                 i, wr_q[i].addr, wr_q[i].data, want[i], exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_busy_ignore();
    logic [159:0] d;
    int lat, busy_low;
    d = rand_buf();
    model_job(d, 6, 16'h0500, 1'b0);
    start_job(d, 6, 16'h0500, 1'b0);
    repeat (5) @(negedge clk);
    start   = 1'b1;
    data_in = rand_buf();
    mode    = 1'b1;
    busy_low = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_low++;
      data_in = rand_buf();
    end
    start = 1'b0;
    n_checks++;
    if (busy_low != 0) $display("FAIL busy_hold: got %0d low cycles, want 0", busy_low);
    else n_pass++;
    wait_done(lat);
    repeat (8) @(negedge clk);
    n_checks++;
    if (lat != 24) $display("FAIL busy_latency: got %0d, want 24", lat); else n_pass++;
    n_checks++;
    if (wr_q.size() != 6 || busy !== 1'b0)
      $display("FAIL busy_no_requeue: got %0d writes busy=%b, want 6 writes busy=0",
               wr_q.size(), busy);
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data)
        $display("FAIL busy_write[%0d]: got %h<=%h, want %h<=%h",
                 i, wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [159:0] d;
    int lat;
    d = rand_buf();
    start_job(d, 2, 16'h0600, 1'b0);
    wait_done(lat);
    // now in DONE: hold start across the DONE edge and the following IDLE edge
    wr_q.delete();
    d = rand_buf();
    model_job(d, 3, 16'h0700, 1'b1);
    data_in = d; num_pix_write = 5'd3; address_write_offset = 16'h0700; mode = 1'b1;
    start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    e0    = cyc;
    start = 1'b0;
    data_in = rand_buf();
    wait_done(lat);
    n_checks++;
    if (lat != 12) $display("FAIL b2b_latency: got %0d, want 12", lat); else n_pass++;
    n_checks++;
    if (wr_q.size() != 3) $display("FAIL b2b_count: got %0d, want 3", wr_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data)
        $display("FAIL b2b_write[%0d]: got %h<=%h, want %h<=%h",
                 i, wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_write();
    logic [159:0] d;
    int lat, c0;
    logic hit;
    d = rand_buf();
    start_job(d, 8, 16'h0800, 1'b0);
    hit = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wr_q.size() == 4 && write_enable === 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
    c0    = cyc;
    n_rst = 1'b0;
    #1;
    n_checks++;
    if (!hit || write_enable !== 1'b0 || cyc != c0)
      $display("FAIL rst_async_we: got reached=%b we=%b edges=%0d, want 1 0 0",
               hit, write_enable, cyc - c0);
    else n_pass++;
    n_checks++;
    if ({busy, done, read_enable, address, w_data} !== '0)
      $display("FAIL rst_async_out: got busy=%b done=%b addr=%h data=%h, want all 0",
               busy, done, address, w_data);
    else n_pass++;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, write_enable, address, w_data} !== '0)
      $display("FAIL rst_release: got busy=%b done=%b we=%b addr=%h data=%h, want all 0",
               busy, done, write_enable, address, w_data);
    else n_pass++;
    d = rand_buf();
    model_job(d, 5, 16'h0900, 1'b0);
    start_job(d, 5, 16'h0900, 1'b0);
    wait_done(lat);
    n_checks++;
    if (lat != 20 || wr_q.size() != 5)
      $display("FAIL rst_rerun: got latency %0d writes %0d, want 20 and 5", lat, wr_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      n_checks++;
      if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data)
        $display("FAIL rst_write[%0d]: got %h<=%h, want %h<=%h",
                 i, wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [159:0] d;
    logic [15:0]  off;
    logic         m;
    int n, lat;
    for (int j = 0; j < 6; j++) begin
      d   = rand_buf();
      n   = $urandom_range(0, 31);
      off = 16'($urandom);
      m   = 1'($urandom);
      if (m) for (int i = 0; i < NP; i++) if ($urandom_range(0, 2) == 0) d[i*8 +: 8] = 8'h00;
      model_job(d, n, off, m);
      start_job(d, n, off, m);
      wait_done(lat);
      n_checks++;
      if (lat != 4 * exp_count(n) || wr_q.size() != exp_q.size())
        $display("FAIL rand%0d_shape: got latency %0d writes %0d, want %0d and %0d",
                 j, lat, wr_q.size(), 4 * exp_count(n), exp_q.size());
      else n_pass++;
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
        n_checks++;
        if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data ||
            wr_q[i].len != 2)
          $display("FAIL rand%0d_write[%0d]: got %h<=%h len %0d, want %h<=%h len 2",
                   j, i, wr_q[i].addr, wr_q[i].data, wr_q[i].len, exp_q[i].addr, exp_q[i].data);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bus_hygiene();
    n_checks++;
    if (unstable != 0) $display("FAIL bus_stable: got %0d changes, want 0", unstable);
    else n_pass++;
    n_checks++;
    if (re_seen != 0) $display("FAIL read_enable_low: got %0d high cycles, want 0", re_seen);
    else n_pass++;
    n_checks++;
    if (xz_seen != 0) $display("FAIL no_xz: got %0d unknown samples, want 0", xz_seen);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_gray_full();
    test_binary();
    test_count_limits();
    test_wrap();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    test_bus_hygiene();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish after 2 ms, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
